// File: rtl/frame_sync.sv
// frame_sync: oversampled optical-line framer with header match and payload bit recovery.
// Define FRAME_SYNC_ERR_CNT_EN to build the saturating header-error counter on err_count.
module frame_sync #(
    parameter int unsigned        OSR          = 4,
    parameter int unsigned        VOTE_THR     = 3,
    parameter int unsigned        HDR_LEN      = 4,
    parameter logic [HDR_LEN-1:0] HDR_PATTERN  = 4'b1100,
    parameter int unsigned        PAYLOAD_BITS = 72
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        signal,
    output logic        bit_data,
    output logic        bit_valid,
    output logic        bit_clk,
    output logic        frame_start,
    output logic        frame_active,
    output logic        frame_done,
    output logic        hdr_err,
    output logic [1:0]  state,
    output logic [15:0] err_count
);

    localparam int unsigned SW   = $clog2(OSR) + 1;
    localparam int unsigned OW   = $clog2(OSR) + 1;
    localparam int unsigned CMAX = (PAYLOAD_BITS > HDR_LEN) ? PAYLOAD_BITS : HDR_LEN;
    localparam int unsigned CW   = $clog2(CMAX) + 1;

    localparam logic [SW-1:0] SLAST = SW'(OSR - 1);
    localparam logic [SW-1:0] HALF  = SW'(OSR / 2);
    localparam logic [OW:0]   THR   = (OW + 1)'(VOTE_THR);
    localparam logic [CW-1:0] HLAST = CW'(HDR_LEN - 1);
    localparam logic [CW-1:0] PLAST = CW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      sidx_q, sidx_d;
    logic [OW-1:0]      ones_q, ones_d;
    logic [CW-1:0]      bcnt_q, bcnt_d;
    logic [HDR_LEN-1:0] hdr_q, hdr_d;
    logic               data_q, data_d;
    logic               valid_q, valid_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               vote;
    logic [HDR_LEN-1:0] hdr_shift;

    // The current sample takes part in the vote of the bit it closes.
    assign vote      = ({1'b0, ones_q} + (OW + 1)'(signal)) >= THR;
    assign hdr_shift = {hdr_q[HDR_LEN-2:0], vote};

    always_comb begin
        state_d = state_q;
        sidx_d  = sidx_q;
        ones_d  = ones_q;
        bcnt_d  = bcnt_q;
        hdr_d   = hdr_q;
        data_d  = 1'b0;
        valid_d = 1'b0;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                sidx_d = '0;
                ones_d = '0;
                bcnt_d = '0;
                hdr_d  = '0;
                if (signal) begin
                    state_d = HEADER;
                    sidx_d  = SW'(1);
                    ones_d  = OW'(1);
                end
            end
            HEADER, PAYLOAD: begin
                if (sidx_q == SLAST) begin
                    sidx_d = '0;
                    ones_d = '0;
                    bcnt_d = bcnt_q + CW'(1);
                    if (state_q == HEADER) begin
                        hdr_d = hdr_shift;
                        if (bcnt_q == HLAST) begin
                            bcnt_d = '0;
                            if (hdr_shift == HDR_PATTERN) begin
                                state_d = PAYLOAD;
                                start_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                                err_d   = 1'b1;
                            end
                        end
                    end else begin
                        data_d  = vote;
                        valid_d = 1'b1;
                        if (bcnt_q == PLAST) begin
                            state_d = GAP;
                            done_d  = 1'b1;
                            bcnt_d  = '0;
                        end
                    end
                end else begin
                    sidx_d = sidx_q + SW'(1);
                    ones_d = ones_q + OW'(signal);
                end
            end
            GAP: begin
                // A line stuck high must drop before a new start bit counts.
                if (!signal) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sidx_q  <= '0;
            ones_q  <= '0;
            bcnt_q  <= '0;
            hdr_q   <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sidx_q  <= sidx_d;
            ones_q  <= ones_d;
            bcnt_q  <= bcnt_d;
            hdr_q   <= hdr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef FRAME_SYNC_ERR_CNT_EN
    logic [15:0] errc_q;

    always_ff @(posedge sample_clk or negedge reset) begin
        if (!reset) begin
            errc_q <= '0;
        end else if (err_d && (errc_q != 16'hFFFF)) begin
            errc_q <= errc_q + 16'd1;
        end
    end

    assign err_count = errc_q;
`else
    assign err_count = 16'd0;
`endif

    assign bit_data     = data_q;
    assign bit_valid    = valid_q;
    assign frame_start  = start_q;
    assign frame_done   = done_q;
    assign hdr_err      = err_q;
    assign state        = state_q;
    assign frame_active = (state_q == PAYLOAD);
    assign bit_clk      = ((state_q == HEADER) || (state_q == PAYLOAD))
                          && (sidx_q < HALF);

endmodule

// File: doc/frame_sync.md
FRAME_SYNC -- requirements
Module: frame_sync

Interface
REQ-001 Parameter OSR, default 4, samples per bit; legal range 2..16.
REQ-002 Parameter VOTE_THR, default 3, minimum count of 1-samples for a bit to be decoded as 1; legal range 1..OSR.
REQ-003 Parameter HDR_LEN, default 4, header length in bits, including the start bit; legal range 2..16.
REQ-004 Parameter HDR_PATTERN, default 4'b1100, expected header bits, MSB first; MSB SHALL be 1.
REQ-005 Parameter PAYLOAD_BITS, default 72, payload bits per frame; legal range 1..4096.
REQ-006 Ports (clock and reset first):
- sample_clk  in  1  oversampling clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- signal  in  1  oversampled optical line, already synchronous to sample_clk.
- bit_data  out  1  decoded payload bit, valid while bit_valid=1.
- bit_valid  out  1  one-cycle strobe per decoded payload bit.
- bit_clk  out  1  recovered bit clock during header/payload, else 0.
- frame_start  out  1  one-cycle pulse on header match; starts downstream CRC.
- frame_active  out  1  high throughout PAYLOAD.
- frame_done  out  1  one-cycle pulse after the last payload bit.
- hdr_err  out  1  one-cycle pulse on header mismatch.
- state  out  2  current FSM state.
- err_count  out  16  header-error count (see Configuration).

Function
REQ-007 FSM states SHALL be IDLE=0, HEADER=1, PAYLOAD=2, GAP=3; any other encoding returns to IDLE.
REQ-008 IDLE: signal=1 -> HEADER, with sample index=1, ones=1, bit count=0; signal=0 -> remain in IDLE, counters held at 0.
REQ-009 HEADER/PAYLOAD: sample index increments every cycle, wraps 0..OSR-1, and ones accumulates signal.
REQ-010 On the cycle with sample index=OSR-1, bit = (ones + signal >= VOTE_THR); ones is cleared and bit count increments.
REQ-011 HEADER: decided bits shift MSB-first into a HDR_LEN-bit register; the start bit is the first decided bit.
REQ-012 After HDR_LEN bits: on match with HDR_PATTERN -> PAYLOAD, frame_start=1 for one cycle, counters cleared; on mismatch -> IDLE, hdr_err=1 for one cycle.
REQ-013 PAYLOAD: each decided bit -> bit_data=bit, bit_valid=1 on the next cycle (latency 1 cycle from the last sample of the bit).
REQ-014 After PAYLOAD_BITS bits -> GAP; frame_done=1 coincides with the final bit_valid.
REQ-015 GAP: remain while signal=1; signal=0 -> IDLE. A line held high SHALL NOT retrigger a frame.
REQ-016 bit_clk = 1 when sample index < OSR/2 (integer division), else 0; forced to 0 in IDLE and GAP.
REQ-017 frame_active = 1 exactly while state=PAYLOAD.
REQ-018 Counter widths: $clog2 of the maximum value plus 1; no counter wraps within a frame.
REQ-019 frame_start, frame_done, hdr_err and bit_valid SHALL each be registered, single-cycle pulses.

Reset
REQ-020 When reset=0, all of the following clear asynchronously: state=IDLE, all counters, the header register, err_count, and every output set to 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no frame_done or hdr_err pulse; the first rising edge after release evaluates IDLE.

Configuration
REQ-022 Macro FRAME_SYNC_ERR_CNT_EN:
- Defined: err_count increments on each hdr_err pulse and saturates at 16'hFFFF.
- Undefined: err_count is tied to 0 and no counter logic is synthesised.
- The port is present in both cases.

Verification
REQ-023 Defaults; reset low for 3 cycles, then released with signal=0 -> all outputs 0, state=0.
REQ-024 Defaults; header 1100 (4 samples per bit), then 72 payload bits alternating 1,0 -> frame_start once, 72 bit_valid pulses with data 1,0,...; frame_done on the 72nd pulse; state 1->2->3->0.
REQ-025 Defaults; header 1110 -> hdr_err pulse, state returns to 0, no frame_start; err_count=1 with the macro, 0 without.
REQ-026 Defaults; a payload bit sampled 1,1,0,1 decodes as 1, and 1,0,0,1 decodes as 0 (VOTE_THR=3).
REQ-027 Defaults; signal held at 1 after frame_done for 20 cycles -> state stays 3; after signal=0 the next 1100 header is accepted.
REQ-028 OSR=8, HDR_LEN=6, HDR_PATTERN=6'b101101, PAYLOAD_BITS=8; reset asserted at payload bit 4 -> immediate return to IDLE, no frame_done.
